// File: rtl/ex_mem_buffer_if.sv
// EX->MEM buffer bus: instruction input side, head-entry output side and the
// exception record. The buffer (slave) accepts from EX and presents to MEM;
// the master side is the surrounding pipeline.
//
// Handshake: a beat moves on a side in any cycle where valid && ready at the
// rising clock edge. The producer holds valid and payload stable until that
// edge. The consumer may change ready freely. in_ready and out_valid are
// driven from flops.
//
// Optional feature macro: EXMEM_FWD_EN adds the fwd_valid/fwd_rd/fwd_data
// forwarding taps.
interface ex_mem_buffer_if #(
  parameter int RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [3:0]      in_alu_control;
  logic [31:0]     in_result;
  logic [7:0]      in_status;
  logic [31:0]     in_store_data;
  logic [RD_W-1:0] in_rd;
  logic            in_mem_read;
  logic            in_mem_write;
  logic            in_reg_write;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [31:0]     out_store_data;
  logic [RD_W-1:0] out_rd;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_reg_write;
  logic            out_zero;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [31:0]     exc_epc;
  logic            exc_ack;
  logic [1:0]      state_dbg;
`ifdef EXMEM_FWD_EN
  logic            fwd_valid;
  logic [RD_W-1:0] fwd_rd;
  logic [31:0]     fwd_data;
`endif

  modport slave (
    input  flush, in_valid, in_pc, in_alu_control, in_result, in_status,
           in_store_data, in_rd, in_mem_read, in_mem_write, in_reg_write,
           out_ready, exc_ack,
    output in_ready, out_valid, out_result, out_store_data, out_rd,
           out_mem_read, out_mem_write, out_reg_write, out_zero,
           exc_valid, exc_cause, exc_epc, state_dbg
`ifdef EXMEM_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport master (
    output flush, in_valid, in_pc, in_alu_control, in_result, in_status,
           in_store_data, in_rd, in_mem_read, in_mem_write, in_reg_write,
           out_ready, exc_ack,
    input  in_ready, out_valid, out_result, out_store_data, out_rd,
           out_mem_read, out_mem_write, out_reg_write, out_zero,
           exc_valid, exc_cause, exc_epc, state_dbg
`ifdef EXMEM_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/ex_mem_buffer.sv
// EX->MEM stage buffer: a 2-entry skid FIFO that holds ALU results plus
// memory/writeback controls. ALU fault flags become a precise exception
// record (cause + EPC), and EX input is stalled until the record is acked.
// Optional feature macro: EXMEM_FWD_EN (forwarding taps from the head entry).
module ex_mem_buffer #(
  parameter bit OVF_TRAP = 1'b1,
  parameter int RD_W     = 5
) (
  input logic           clk,
  input logic           rst,
  ex_mem_buffer_if.slave bus
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2,
    S_EXC   = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]     result;
    logic [31:0]     store_data;
    logic [RD_W-1:0] rd;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            zero;
  } entry_t;

  state_t      state_q, state_n;
  logic [1:0]  count_q, count_n;
  entry_t      head_q, tail_q, in_entry;
  logic        in_ready_q, out_valid_q, exc_valid_q, exc_n;
  logic [3:0]  exc_cause_q;
  logic [31:0] exc_epc_q;
  logic        accept, pop, fault;
  logic [3:0]  fault_cause;

  // Carry, negative and the two low status bits never influence the buffer.
  wire unused_status = &{1'b0, bus.in_status[5:4], bus.in_status[1:0]};

  // Fault classification of the incoming instruction; div0 wins over
  // misalign, which wins over multiply overflow.
  always_comb begin
    fault       = 1'b0;
    fault_cause = 4'd0;
    if (bus.in_alu_control == 4'd4 && bus.in_status[2]) begin
      fault       = 1'b1;
      fault_cause = 4'd1;
    end else if ((bus.in_alu_control == 4'd12 || bus.in_alu_control == 4'd13)
                 && bus.in_status[3]) begin
      fault       = 1'b1;
      fault_cause = bus.in_mem_write ? 4'd5 : 4'd4;
    end else if (OVF_TRAP && bus.in_alu_control == 4'd5 && bus.in_status[6]) begin
      fault       = 1'b1;
      fault_cause = 4'd12;
    end
  end

  // Entry image of the incoming instruction; a faulting one is neutered so
  // it cannot touch memory or the register file.
  always_comb begin
    in_entry.result     = bus.in_result;
    in_entry.store_data = bus.in_store_data;
    in_entry.rd         = bus.in_rd;
    in_entry.mem_read   = bus.in_mem_read  && !fault;
    in_entry.mem_write  = bus.in_mem_write && !fault;
    in_entry.reg_write  = bus.in_reg_write && !fault;
    in_entry.zero       = bus.in_status[7];
  end

  // Handshake qualification, occupancy and next state. flush suppresses both
  // the same-cycle accept and the same-cycle pop.
  always_comb begin
    accept  = bus.in_valid && in_ready_q && !bus.flush;
    pop     = out_valid_q && bus.out_ready && !bus.flush;
    count_n = bus.flush ? 2'd0 : (count_q + 2'(accept) - 2'(pop));
    if (exc_valid_q) exc_n = !bus.exc_ack;
    else             exc_n = accept && fault;
    if (exc_n)               state_n = S_EXC;
    else if (count_n == 2'd0) state_n = S_EMPTY;
    else if (count_n == 2'd1) state_n = S_ONE;
    else                      state_n = S_TWO;
  end

  // Control state, registered handshake outputs and exception record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 4'd0;
      exc_epc_q   <= 32'd0;
    end else begin
      state_q     <= state_n;
      count_q     <= count_n;
      in_ready_q  <= (state_n == S_EMPTY) || (state_n == S_ONE);
      out_valid_q <= (count_n != 2'd0);
      exc_valid_q <= exc_n;
      if (accept && fault) begin
        exc_cause_q <= fault_cause;
        exc_epc_q   <= bus.in_pc;
      end
    end
  end

  // Entry storage: head feeds MEM directly, tail shifts into head on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) head_q <= in_entry;
        else                                             tail_q <= in_entry;
      end
      if (pop && count_q == 2'd2) head_q <= tail_q;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = head_q.result;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_mem_read   = head_q.mem_read;
  assign bus.out_mem_write  = head_q.mem_write;
  assign bus.out_reg_write  = head_q.reg_write;
  assign bus.out_zero       = head_q.zero;
  assign bus.exc_valid      = exc_valid_q;
  assign bus.exc_cause      = exc_cause_q;
  assign bus.exc_epc        = exc_epc_q;
  assign bus.state_dbg      = state_q;

`ifdef EXMEM_FWD_EN
  // Forwarding taps: head entry that will write a non-zero register.
  assign bus.fwd_valid = out_valid_q && head_q.reg_write && (head_q.rd != '0);
  assign bus.fwd_rd    = head_q.rd;
  assign bus.fwd_data  = head_q.result;
`endif
endmodule
